// File: rtl/onehot_sequencer_if.sv
// ---------------------------------------------------------------------------
// onehot_sequencer_if
//   Bundles the control inputs and the LED/display outputs of the one-hot
//   sequencer. clk and rst stay plain ports on the design.
//
//   master : switch/button side (drives enable/load/idx_in/run/dir, reads outputs)
//   slave  : the sequencer itself
//
//   enable  : 0 forces IDLE (LEDs dark)
//   load    : 1-cycle strobe, capture idx_in as current position
//   idx_in  : position to load (0..7)
//   run     : level, 1 = step automatically, 0 = hold
//   dir     : 0 = step up, 1 = step down
//   led_out : one-hot LED pattern, 8'h00 when not valid
//   cur_idx : current position, for the 7-segment path
//   valid   : 1 in HOLD/RUN, 0 in IDLE
// ---------------------------------------------------------------------------
interface onehot_sequencer_if;
    logic       enable;
    logic       load;
    logic [2:0] idx_in;
    logic       run;
    logic       dir;
    logic [7:0] led_out;
    logic [2:0] cur_idx;
    logic       valid;

    modport master (
        output enable, load, idx_in, run, dir,
        input  led_out, cur_idx, valid
    );

    modport slave (
        input  enable, load, idx_in, run, dir,
        output led_out, cur_idx, valid
    );
endinterface

// File: rtl/onehot_sequencer.sv
// ---------------------------------------------------------------------------
// onehot_sequencer
//   Inverse of the board's 8->3 priority encoder: turns a 3-bit position into
//   an 8-bit one-hot LED pattern. In RUN the lit position steps up or down once
//   every TICK_DIV clocks, wrapping 7<->0. cur_idx/valid feed the 7-segment
//   path so the displayed digit tracks the lit LED.
//
//   Parameters
//     TICK_DIV : clk cycles per step in RUN (>= 2)
//     CNT_W    : prescaler width, 2**CNT_W >= TICK_DIV
//
//   Ports
//     clk : system clock, all state on the rising edge
//     rst : synchronous reset, active-high, highest priority
//     bus : onehot_sequencer_if.slave (controls in, LED/display out)
//
//   All outputs are registered; they are loaded from the next-state values so
//   an input sampled on edge N is visible right after edge N.
// ---------------------------------------------------------------------------
module onehot_sequencer #(
    parameter int TICK_DIV = 5000000,
    parameter int CNT_W    = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    onehot_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [2:0]       pos_q,   pos_d;
    logic [CNT_W-1:0] pre_q,   pre_d;
    logic [7:0]       led_q;
    logic             valid_q;
    logic             valid_d;

    // -----------------------------------------------------------------------
    // Next-state. enable=0 overrides everything except reset; position is
    // retained across IDLE so re-enabling without a load would be harmless,
    // but leaving IDLE always requires a load.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        pre_d   = pre_q;

        if (!bus.enable) begin
            state_d = IDLE;
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        state_d = HOLD;
                        pos_d   = bus.idx_in;
                        pre_d   = '0;
                    end
                end

                HOLD: begin
                    // load and run may land on the same edge; both apply.
                    if (bus.load)
                        pos_d = bus.idx_in;
                    if (bus.run) begin
                        state_d = RUN;
                        pre_d   = '0;
                    end
                end

                RUN: begin
                    if (!bus.run) begin
                        state_d = HOLD;
                        pre_d   = '0;
                        if (bus.load)
                            pos_d = bus.idx_in;
                    end else if (bus.load) begin
                        // A load restarts the interval and suppresses a
                        // coincident tick.
                        pos_d = bus.idx_in;
                        pre_d = '0;
                    end else if (pre_q == TICK_LAST) begin
                        // 3-bit arithmetic gives the 7<->0 wrap for free.
                        pos_d = bus.dir ? (pos_q - 3'd1) : (pos_q + 3'd1);
                        pre_d = '0;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                    pre_d   = '0;
                end
            endcase
        end
    end

    assign valid_d = (state_d != IDLE);

    // -----------------------------------------------------------------------
    // State and registered outputs. Outputs are derived from next-state so
    // they align with the state they describe; led_q can only ever hold a
    // single set bit or zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= 3'd0;
            pre_q   <= '0;
            led_q   <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            pre_q   <= pre_d;
            led_q   <= valid_d ? (8'b1 << pos_d) : 8'h00;
            valid_q <= valid_d;
        end
    end

    assign bus.led_out = led_q;
    assign bus.cur_idx = pos_q;
    assign bus.valid   = valid_q;

endmodule

// File: tb/tb_onehot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_onehot_sequencer
//   Directed bench for onehot_sequencer with TICK_DIV=4. Inputs are driven
//   1 time unit after each rising edge and outputs are sampled at the same
//   point, i.e. well away from the active edge.
// ---------------------------------------------------------------------------
module tb_onehot_sequencer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    onehot_sequencer_if bus ();

    onehot_sequencer #(
        .TICK_DIV (4),
        .CNT_W    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        bus.idx_in = 3'd0;
        bus.run    = 1'b0;
        bus.dir    = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.led_out !== 8'h00) begin
            errors++; $display("FAIL reset_led actual=%h required=00", bus.led_out);
        end
        checks++;
        if (bus.cur_idx !== 3'd0) begin
            errors++; $display("FAIL reset_idx actual=%0d required=0", bus.cur_idx);
        end
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid actual=%b required=0", bus.valid);
        end
        // load pulses with enable low must be ignored
        rst        = 1'b0;
        bus.idx_in = 3'd5;
        for (int i = 0; i < 3; i++) begin
            bus.load = 1'b1;
            tick();
            bus.load = 1'b0;
            checks++;
            if (bus.led_out !== 8'h00 || bus.valid !== 1'b0 || bus.cur_idx !== 3'd0) begin
                errors++;
                $display("FAIL disabled_load led=%h valid=%b idx=%0d required led=00 valid=0 idx=0",
                         bus.led_out, bus.valid, bus.cur_idx);
            end
        end
    endtask

    task automatic test_load_enable();
        bus.enable = 1'b1;
        bus.load   = 1'b1;
        bus.idx_in = 3'd5;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.led_out !== 8'h20 || bus.cur_idx !== 3'd5 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL load5 led=%h idx=%0d valid=%b required led=20 idx=5 valid=1",
                     bus.led_out, bus.cur_idx, bus.valid);
        end
        bus.enable = 1'b0;
        tick();
        checks++;
        if (bus.led_out !== 8'h00 || bus.valid !== 1'b0 || bus.cur_idx !== 3'd5) begin
            errors++;
            $display("FAIL disable led=%h valid=%b idx=%0d required led=00 valid=0 idx=5",
                     bus.led_out, bus.valid, bus.cur_idx);
        end
        // run is ignored in IDLE
        bus.run = 1'b1;
        tick();
        tick();
        bus.run = 1'b0;
        checks++;
        if (bus.valid !== 1'b0 || bus.led_out !== 8'h00) begin
            errors++;
            $display("FAIL idle_run valid=%b led=%h required valid=0 led=00", bus.valid, bus.led_out);
        end
    endtask

    task automatic test_run_up();
        logic [7:0] exp;
        bus.enable = 1'b1;
        bus.load   = 1'b1;
        bus.idx_in = 3'd6;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.led_out !== 8'h40) begin
            errors++; $display("FAIL up_load6 actual=%h required=40", bus.led_out);
        end
        bus.run = 1'b1;
        bus.dir = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = (k <= 4) ? 8'h40 : (k <= 8) ? 8'h80 : 8'h01;
            checks++;
            if (bus.led_out !== exp) begin
                errors++; $display("FAIL run_up cycle=%0d actual=%h required=%h", k, bus.led_out, exp);
            end
        end
        bus.run = 1'b0;
        tick();
        checks++;
        if (bus.led_out !== 8'h01 || bus.cur_idx !== 3'd0) begin
            errors++;
            $display("FAIL up_stop led=%h idx=%0d required led=01 idx=0", bus.led_out, bus.cur_idx);
        end
    endtask

    task automatic test_run_down();
        logic [7:0] exp;
        bus.load   = 1'b1;
        bus.idx_in = 3'd1;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.led_out !== 8'h02) begin
            errors++; $display("FAIL down_load1 actual=%h required=02", bus.led_out);
        end
        bus.run = 1'b1;
        bus.dir = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp = (k <= 4) ? 8'h02 : (k <= 8) ? 8'h01 : (k <= 12) ? 8'h80 : 8'h40;
            checks++;
            if (bus.led_out !== exp) begin
                errors++; $display("FAIL run_down cycle=%0d actual=%h required=%h", k, bus.led_out, exp);
            end
        end
        // drop run mid-interval: pattern must freeze well past the next would-be tick
        bus.run = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (bus.led_out !== 8'h40 || bus.valid !== 1'b1) begin
                errors++;
                $display("FAIL frozen cycle=%0d led=%h valid=%b required led=40 valid=1",
                         k, bus.led_out, bus.valid);
            end
        end
    endtask

    task automatic test_load_on_tick();
        logic [7:0] exp;
        // position 6 held; enter RUN up, prescaler goes 0,1,2,3 on edges 1..4
        bus.run = 1'b1;
        bus.dir = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if (bus.led_out !== 8'h40) begin
            errors++; $display("FAIL pre_tick actual=%h required=40", bus.led_out);
        end
        // edge 5 would step to 80; a load there wins
        bus.load   = 1'b1;
        bus.idx_in = 3'd3;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp = (k < 4) ? 8'h08 : 8'h10;
            checks++;
            if (bus.led_out !== exp) begin
                errors++; $display("FAIL load_tick cycle=%0d actual=%h required=%h", k, bus.led_out, exp);
            end
            if (k < 4) tick();
        end
    endtask

    task automatic test_reset_mid_run();
        // still running up from position 4
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (bus.led_out !== 8'h00 && !$onehot(bus.led_out)) begin
                errors++; $display("FAIL onehot cycle=%0d actual=%h required=onehot", k, bus.led_out);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.led_out !== 8'h00 || bus.cur_idx !== 3'd0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_run led=%h idx=%0d valid=%b required led=00 idx=0 valid=0",
                     bus.led_out, bus.cur_idx, bus.valid);
        end
        // enable and run still high, but no load: must stay dark
        tick();
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.led_out !== 8'h00) begin
            errors++;
            $display("FAIL post_rst_idle valid=%b led=%h required valid=0 led=00", bus.valid, bus.led_out);
        end
        // load + run together from IDLE: HOLD first, RUN on the next edge
        bus.load   = 1'b1;
        bus.idx_in = 3'd7;
        tick();
        bus.load = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (bus.led_out !== ((k <= 4) ? 8'h80 : 8'h01)) begin
                errors++;
                $display("FAIL reload_run cycle=%0d actual=%h required=%h", k, bus.led_out,
                         (k <= 4) ? 8'h80 : 8'h01);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_load_enable();
        test_run_up();
        test_run_down();
        test_load_on_tick();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
